// File: rtl/lab2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab2_pkg
// Brief    : Shared calendar types, constants and days-in-month helper.
// Revision : 1.0
// ============================================================================
package lab2_pkg;

    typedef logic [3:0] month_t;
    typedef logic [4:0] date_t;
    typedef logic [3:0] bcd_t;

    localparam month_t MAX_MONTH = 4'd12;
    localparam date_t  DAYS_31   = 5'd31;
    localparam date_t  DAYS_30   = 5'd30;

    // Illegal months fall through to 31; callers sanitise the month first.
    function automatic date_t dim(input month_t m, input date_t feb);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: dim = DAYS_30;
            4'd2:                    dim = feb;
            default:                 dim = DAYS_31;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd2.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd2
// Brief    : Binary 0..31 to two BCD digits (tens, ones).
// Revision : 1.0
// ============================================================================
module bin2bcd2
    import lab2_pkg::*;
(
    input  logic [4:0] i_bin,
    output bcd_t       o_tens,
    output bcd_t       o_ones
);

    always_comb begin
        if (i_bin >= 5'd30) begin
            o_tens = 4'd3;
            o_ones = 4'(i_bin - 5'd30);
        end else if (i_bin >= 5'd20) begin
            o_tens = 4'd2;
            o_ones = 4'(i_bin - 5'd20);
        end else if (i_bin >= 5'd10) begin
            o_tens = 4'd1;
            o_ones = 4'(i_bin - 5'd10);
        end else begin
            o_tens = 4'd0;
            o_ones = i_bin[3:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/calendar_ctr.sv
`default_nettype none
// ============================================================================
// Module   : calendar_ctr
// Brief    : Month/date calendar stage advanced by the end-of-day carry.
// Revision : 1.0
// ============================================================================
module calendar_ctr
    import lab2_pkg::*;
#(
    parameter date_t  FEB_DAYS  = 5'd28,
    parameter month_t RST_MONTH = 4'd1,
    parameter date_t  RST_DATE  = 5'd1
)(
    input  logic       Pulse,
    input  logic       Reset,
    input  logic       Timeset,
    input  logic       DateAdv,
    input  logic       MonthAdv,
    input  logic       DayCarry,
    output logic [3:0] Month,
    output logic [4:0] Date,
    output logic [3:0] Month1,
    output logic [3:0] Month0,
    output logic [3:0] Date1,
    output logic [3:0] Date0,
    output logic       YearCarry
);

    month_t r_month;
    date_t  r_date;
    logic   r_year_carry;

    month_t w_month_s;
    date_t  w_date_s;
    date_t  w_dim_cur;
    date_t  w_dim_next;
    month_t w_month_inc;
    month_t w_month_nx;
    date_t  w_date_nx;
    logic   w_year_nx;

    // Sanitised view of the state: any illegal month/date is treated as 1.
    always_comb begin
        w_month_s = ((r_month == 4'd0) || (r_month > MAX_MONTH)) ? 4'd1 : r_month;
        w_dim_cur = dim(w_month_s, FEB_DAYS);
        w_date_s  = ((r_date == 5'd0) || (r_date > w_dim_cur)) ? 5'd1 : r_date;
        w_month_inc = (w_month_s == MAX_MONTH) ? 4'd1 : w_month_s + 4'd1;
    end

    always_comb begin
        w_month_nx = w_month_s;
        w_date_nx  = w_date_s;
        w_year_nx  = 1'b0;
        w_dim_next = w_dim_cur;
        if (Timeset) begin
            if (MonthAdv)
                w_month_nx = w_month_inc;
            if (DateAdv)
                w_date_nx = (w_date_s >= w_dim_cur) ? 5'd1 : w_date_s + 5'd1;
            w_dim_next = dim(w_month_nx, FEB_DAYS);
            if (w_date_nx > w_dim_next)
                w_date_nx = w_dim_next;
        end else if (DayCarry) begin
            if (w_date_s < w_dim_cur) begin
                w_date_nx = w_date_s + 5'd1;
            end else begin
                w_date_nx  = 5'd1;
                w_month_nx = w_month_inc;
                w_year_nx  = (w_month_s == MAX_MONTH);
            end
        end
    end

    always_ff @(posedge Pulse) begin
        if (!Reset) begin
            r_month      <= RST_MONTH;
            r_date       <= RST_DATE;
            r_year_carry <= 1'b0;
        end else begin
            r_month      <= w_month_nx;
            r_date       <= w_date_nx;
            r_year_carry <= w_year_nx;
        end
    end

    assign Month     = r_month;
    assign Date      = r_date;
    assign YearCarry = r_year_carry;

    bin2bcd2 u_month_bcd (
        .i_bin  ({1'b0, r_month}),
        .o_tens (Month1),
        .o_ones (Month0)
    );

    bin2bcd2 u_date_bcd (
        .i_bin  (r_date),
        .o_tens (Date1),
        .o_ones (Date0)
    );

endmodule
`default_nettype wire

// File: tb/tb_calendar_ctr.sv
`default_nettype none
// ============================================================================
// Module   : tb_calendar_ctr
// Brief    : Directed self-checking bench for calendar_ctr.
// Revision : 1.0
// ============================================================================
module tb_calendar_ctr;

    logic       Pulse = 1'b0;
    logic       Reset = 1'b1;
    logic       Timeset = 1'b0;
    logic       DateAdv = 1'b0;
    logic       MonthAdv = 1'b0;
    logic       DayCarry = 1'b0;
    logic [3:0] Month;
    logic [4:0] Date;
    logic [3:0] Month1, Month0, Date1, Date0;
    logic       YearCarry;

    int total = 0;
    int bad   = 0;

    calendar_ctr dut (
        .Pulse     (Pulse),
        .Reset     (Reset),
        .Timeset   (Timeset),
        .DateAdv   (DateAdv),
        .MonthAdv  (MonthAdv),
        .DayCarry  (DayCarry),
        .Month     (Month),
        .Date      (Date),
        .Month1    (Month1),
        .Month0    (Month0),
        .Date1     (Date1),
        .Date0     (Date0),
        .YearCarry (YearCarry)
    );

    always #5 Pulse = ~Pulse;

    task automatic step(input int n);
        repeat (n) @(posedge Pulse);
        #1;
    endtask

    task automatic drive(input logic ts, input logic da, input logic ma, input logic dc);
        Timeset = ts; DateAdv = da; MonthAdv = ma; DayCarry = dc;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        Reset = 1'b0;
        step(2);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({Month, Date} !== {4'd1, 5'd1}) begin
            bad++; $display("FAIL reset_md: got %0d/%0d want 1/1", Month, Date);
        end
        total++;
        if ({Month1, Month0, Date1, Date0} !== 16'h0101) begin
            bad++; $display("FAIL reset_bcd: got %h want 0101", {Month1, Month0, Date1, Date0});
        end
        total++;
        if (YearCarry !== 1'b0) begin
            bad++; $display("FAIL reset_yc: got %b want 0", YearCarry);
        end
        step(3);
        total++;
        if ({Month, Date} !== {4'd1, 5'd1}) begin
            bad++; $display("FAIL reset_idle_hold: got %0d/%0d want 1/1", Month, Date);
        end
    endtask

    task automatic test_set_dec31();
        drive(1, 1, 1, 0);
        step(11);
        total++;
        if ({Month, Date} !== {4'd12, 5'd12}) begin
            bad++; $display("FAIL set_both11: got %0d/%0d want 12/12", Month, Date);
        end
        total++;
        if (YearCarry !== 1'b0) begin
            bad++; $display("FAIL set_yc: got %b want 0", YearCarry);
        end
        drive(1, 1, 0, 0);
        step(19);
        drive(1, 0, 0, 0);
        total++;
        if ({Month, Date} !== {4'd12, 5'd31}) begin
            bad++; $display("FAIL set_dec31: got %0d/%0d want 12/31", Month, Date);
        end
        total++;
        if ({Month1, Month0, Date1, Date0} !== 16'h1231) begin
            bad++; $display("FAIL dec31_bcd: got %h want 1231", {Month1, Month0, Date1, Date0});
        end
    endtask

    task automatic test_year_rollover();
        drive(0, 0, 0, 1);
        step(1);
        drive(0, 0, 0, 0);
        total++;
        if ({Month, Date} !== {4'd1, 5'd1}) begin
            bad++; $display("FAIL year_roll_md: got %0d/%0d want 1/1", Month, Date);
        end
        total++;
        if (YearCarry !== 1'b1) begin
            bad++; $display("FAIL year_roll_yc: got %b want 1", YearCarry);
        end
        step(1);
        total++;
        if (YearCarry !== 1'b0) begin
            bad++; $display("FAIL year_roll_yc_clear: got %b want 0", YearCarry);
        end
    endtask

    task automatic test_month_ends();
        do_reset();
        drive(1, 1, 1, 0);
        step(1);
        drive(1, 1, 0, 0);
        step(26);
        drive(1, 0, 0, 0);
        total++;
        if ({Month, Date} !== {4'd2, 5'd28}) begin
            bad++; $display("FAIL set_feb28: got %0d/%0d want 2/28", Month, Date);
        end
        drive(0, 0, 0, 1);
        step(1);
        drive(0, 0, 0, 0);
        total++;
        if ({Month, Date} !== {4'd3, 5'd1}) begin
            bad++; $display("FAIL feb_end: got %0d/%0d want 3/1", Month, Date);
        end
        drive(1, 0, 1, 0);
        step(1);
        drive(1, 1, 0, 0);
        step(29);
        drive(1, 0, 0, 0);
        total++;
        if ({Month, Date} !== {4'd4, 5'd30}) begin
            bad++; $display("FAIL set_apr30: got %0d/%0d want 4/30", Month, Date);
        end
        drive(0, 0, 0, 1);
        step(1);
        drive(0, 0, 0, 0);
        total++;
        if ({Month, Date, YearCarry} !== {4'd5, 5'd1, 1'b0}) begin
            bad++; $display("FAIL apr_end: got %0d/%0d yc=%b want 5/1 yc=0", Month, Date, YearCarry);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 0, 1);
        step(3);
        drive(0, 0, 0, 0);
        total++;
        if ({Month, Date} !== {4'd5, 5'd4}) begin
            bad++; $display("FAIL back_to_back: got %0d/%0d want 5/4", Month, Date);
        end
    endtask

    task automatic test_clamp_wrap();
        do_reset();
        drive(1, 1, 0, 0);
        step(30);
        drive(1, 0, 1, 0);
        step(1);
        drive(1, 0, 0, 0);
        total++;
        if ({Month, Date} !== {4'd2, 5'd28}) begin
            bad++; $display("FAIL clamp_jan31: got %0d/%0d want 2/28", Month, Date);
        end
        drive(1, 1, 0, 0);
        step(1);
        total++;
        if ({Month, Date} !== {4'd2, 5'd1}) begin
            bad++; $display("FAIL feb_manual_wrap: got %0d/%0d want 2/1", Month, Date);
        end
        drive(1, 0, 1, 0);
        step(2);
        drive(1, 1, 0, 0);
        step(29);
        total++;
        if ({Month, Date} !== {4'd4, 5'd30}) begin
            bad++; $display("FAIL set_apr30b: got %0d/%0d want 4/30", Month, Date);
        end
        step(1);
        drive(1, 0, 0, 0);
        total++;
        if ({Month, Date} !== {4'd4, 5'd1}) begin
            bad++; $display("FAIL apr_manual_wrap: got %0d/%0d want 4/1", Month, Date);
        end
        drive(1, 0, 1, 0);
        step(9);
        drive(1, 0, 0, 0);
        total++;
        if ({Month, Date, YearCarry} !== {4'd1, 5'd1, 1'b0}) begin
            bad++; $display("FAIL manual_dec_wrap: got %0d/%0d yc=%b want 1/1 yc=0", Month, Date, YearCarry);
        end
    endtask

    task automatic test_gating();
        drive(1, 1, 1, 0);
        step(2);
        drive(1, 1, 0, 0);
        step(2);
        drive(0, 1, 1, 0);
        total++;
        if ({Month, Date} !== {4'd3, 5'd5}) begin
            bad++; $display("FAIL gate_setup: got %0d/%0d want 3/5", Month, Date);
        end
        step(10);
        total++;
        if ({Month, Date} !== {4'd3, 5'd5}) begin
            bad++; $display("FAIL gate_run_adv: got %0d/%0d want 3/5", Month, Date);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 1);
            step(1);
            drive(1, 0, 0, 0);
            step(1);
        end
        total++;
        if ({Month, Date, YearCarry} !== {4'd3, 5'd5, 1'b0}) begin
            bad++; $display("FAIL gate_set_carry: got %0d/%0d yc=%b want 3/5 yc=0", Month, Date, YearCarry);
        end
        drive(1, 1, 1, 1);
        Reset = 1'b0;
        step(1);
        total++;
        if ({Month, Date, YearCarry} !== {4'd1, 5'd1, 1'b0}) begin
            bad++; $display("FAIL reset_override: got %0d/%0d yc=%b want 1/1 yc=0", Month, Date, YearCarry);
        end
        Reset = 1'b1;
        drive(0, 0, 0, 0);
        step(1);
    endtask

    initial begin
        step(1);
        test_reset();
        test_set_dec31();
        test_year_rollover();
        test_month_ends();
        test_back_to_back();
        test_clamp_wrap();
        test_gating();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
